// File: rtl/ctr_m_pkg.sv
// ctr_m_pkg: shared constants for the M-stage control register.
//   opcode_e  - primary opcodes decoded by ctr_m (byte/halfword ops are
//               only acted on when BYTE_MEM_EN is defined)
//   funct_e   - SPECIAL function codes
//   fwdsel_e  - encoding of the forwardable value available at M
package ctr_m_pkg;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00,
        OP_J       = 6'h02,
        OP_JAL     = 6'h03,
        OP_BEQ     = 6'h04,
        OP_ORI     = 6'h0d,
        OP_LUI     = 6'h0f,
        OP_LB      = 6'h20,
        OP_LH      = 6'h21,
        OP_LW      = 6'h23,
        OP_LBU     = 6'h24,
        OP_LHU     = 6'h25,
        OP_SB      = 6'h28,
        OP_SH      = 6'h29,
        OP_SW      = 6'h2b
    } opcode_e;

    typedef enum logic [5:0] {
        FN_JR   = 6'h08,
        FN_ADDU = 6'h21,
        FN_SUBU = 6'h23
    } funct_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_AO   = 2'b01,
        FWD_PC4  = 2'b10
    } fwdsel_e;

    localparam logic [4:0] RA_REG = 5'd31;

endpackage

// File: rtl/ctr_m_if.sv
// ctr_m_if: E/M boundary inputs and M-stage control outputs of ctr_m.
//   master : pipeline side - drives instr_e, stall_m, flush_m, ao_lo_m
//   slave  : ctr_m         - drives op_m, func_m, RegWr_M, A3_M, DMWr_M,
//                            BE_M, Tnew_M, FWDSEL_M
interface ctr_m_if;
    logic [31:0] instr_e;
    logic        stall_m;
    logic        flush_m;
    logic [1:0]  ao_lo_m;
    logic [5:0]  op_m;
    logic [5:0]  func_m;
    logic        RegWr_M;
    logic [4:0]  A3_M;
    logic        DMWr_M;
    logic [3:0]  BE_M;
    logic [1:0]  Tnew_M;
    logic [1:0]  FWDSEL_M;

    modport master (
        output instr_e, stall_m, flush_m, ao_lo_m,
        input  op_m, func_m, RegWr_M, A3_M, DMWr_M, BE_M, Tnew_M, FWDSEL_M
    );

    modport slave (
        input  instr_e, stall_m, flush_m, ao_lo_m,
        output op_m, func_m, RegWr_M, A3_M, DMWr_M, BE_M, Tnew_M, FWDSEL_M
    );
endinterface

// File: rtl/ctr_m_mem_be_gen.sv
// mem_be_gen: byte-enable generator for byte/halfword/word stores.
// Present only when BYTE_MEM_EN is defined.
//   op       in  6  M-stage opcode
//   ao_lo    in  2  low address bits of the store
//   be       out 4  data-memory byte enables
//   store_ok out 1  store is aligned and may be performed
`ifdef BYTE_MEM_EN
module mem_be_gen
    import ctr_m_pkg::*;
(
    input  logic [5:0] op,
    input  logic [1:0] ao_lo,
    output logic [3:0] be,
    output logic       store_ok
);
    always_comb begin
        be       = '0;
        store_ok = 1'b0;
        if (op == OP_SW) begin
            // Misaligned words are dropped rather than trapped.
            if (ao_lo == 2'b00) begin
                be       = '1;
                store_ok = 1'b1;
            end
        end else if (op == OP_SB) begin
            be       = 4'b0001 << ao_lo;
            store_ok = 1'b1;
        end else if (op == OP_SH) begin
            if (!ao_lo[0]) begin
                be       = ao_lo[1] ? 4'b1100 : 4'b0011;
                store_ok = 1'b1;
            end
        end
    end
endmodule
`endif

// File: rtl/ctr_m.sv
// ctr_m: M-stage control register of the five-stage MIPS pipeline.
// Latches the E-stage instruction and decodes M-stage controls from it.
//   clk    in  pipeline clock
//   rst_n  in  synchronous active-low reset
//   bus    ctr_m_if.slave: instr_e/stall_m/flush_m/ao_lo_m in;
//          op_m/func_m (to W controller op_34/func_34), RegWr_M, A3_M,
//          DMWr_M, BE_M, Tnew_M, FWDSEL_M out
// Optional feature: define BYTE_MEM_EN for sb/sh/lb/lbu/lh/lhu support.
module ctr_m
    import ctr_m_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    ctr_m_if.slave   bus
);
    logic [31:0] instr_m_q, instr_m_d;

    // Flush loads a bubble even while stalled.
    always_comb begin
        instr_m_d = instr_m_q;
        if (bus.flush_m) begin
            instr_m_d = '0;
        end else if (!bus.stall_m) begin
            instr_m_d = bus.instr_e;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_m_q <= '0;
        end else begin
            instr_m_q <= instr_m_d;
        end
    end

    logic [5:0] op, fn;
    logic [4:0] rt, rd;
    logic       is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_jal;
    logic       is_load, is_alu, is_store;
    logic [4:0] a3;
    logic       regwr;

    always_comb begin
        op = instr_m_q[31:26];
        fn = instr_m_q[5:0];
        rt = instr_m_q[20:16];
        rd = instr_m_q[15:11];

        is_addu = (op == OP_SPECIAL) && (fn == FN_ADDU);
        is_subu = (op == OP_SPECIAL) && (fn == FN_SUBU);
        is_ori  = (op == OP_ORI);
        is_lui  = (op == OP_LUI);
        is_lw   = (op == OP_LW);
        is_sw   = (op == OP_SW);
        is_jal  = (op == OP_JAL);
`ifdef BYTE_MEM_EN
        is_load  = is_lw || (op == OP_LB) || (op == OP_LBU)
                         || (op == OP_LH) || (op == OP_LHU);
        is_store = is_sw || (op == OP_SB) || (op == OP_SH);
`else
        is_load  = is_lw;
        is_store = is_sw;
`endif
        is_alu = is_addu || is_subu || is_ori || is_lui;

        a3 = '0;
        if (is_addu || is_subu) begin
            a3 = rd;
        end else if (is_ori || is_lui || is_load) begin
            a3 = rt;
        end else if (is_jal) begin
            a3 = RA_REG;
        end

        // Writes to $0 are suppressed and therefore never forwarded.
        regwr = (is_alu || is_load || is_jal) && (a3 != '0);
    end

`ifdef BYTE_MEM_EN
    logic [3:0] be_gen;
    logic       store_ok;
    logic       unused_bits;

    mem_be_gen u_mem_be_gen (
        .op       (op),
        .ao_lo    (bus.ao_lo_m),
        .be       (be_gen),
        .store_ok (store_ok)
    );

    always_comb begin
        bus.DMWr_M  = is_store && store_ok;
        bus.BE_M    = be_gen;
        unused_bits = ^{instr_m_q[25:21], instr_m_q[10:6]};
    end
`else
    logic unused_bits;

    always_comb begin
        bus.DMWr_M  = is_store;
        bus.BE_M    = is_store ? 4'b1111 : 4'b0000;
        unused_bits = ^{instr_m_q[25:21], instr_m_q[10:6], bus.ao_lo_m};
    end
`endif

    always_comb begin
        bus.op_m     = op;
        bus.func_m   = fn;
        bus.A3_M     = a3;
        bus.RegWr_M  = regwr;
        bus.Tnew_M   = is_load ? 2'd1 : 2'd0;
        bus.FWDSEL_M = FWD_NONE;
        if (regwr) begin
            if (is_jal) begin
                bus.FWDSEL_M = FWD_PC4;
            end else if (is_alu) begin
                bus.FWDSEL_M = FWD_AO;
            end
        end
    end

endmodule

// File: tb/tb_ctr_m.sv
module tb_ctr_m;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       regwr;
        logic [4:0] a3;
        logic       dmwr;
        logic [3:0] be;
        logic [1:0] tnew;
        logic [1:0] fwd;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb_q[$];
    logic [31:0] m_instr;

    ctr_m_if bus ();

    ctr_m dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Reference decode of the latched M-stage word.
    function automatic exp_t model(input logic [31:0] w, input logic [1:0] ao);
        exp_t e;
        logic wr;
        e = '0;
        wr = 1'b0;
        e.op = w[31:26];
        e.fn = w[5:0];
        case (w[31:26])
            6'h00: if (w[5:0] == 6'h21 || w[5:0] == 6'h23) begin
                wr = 1'b1; e.a3 = w[15:11]; e.fwd = 2'b01;
            end
            6'h0d, 6'h0f: begin wr = 1'b1; e.a3 = w[20:16]; e.fwd = 2'b01; end
            6'h23: begin wr = 1'b1; e.a3 = w[20:16]; e.tnew = 2'd1; end
            6'h03: begin wr = 1'b1; e.a3 = 5'd31; e.fwd = 2'b10; end
`ifdef BYTE_MEM_EN
            6'h2b: if (ao == 2'b00) begin e.dmwr = 1'b1; e.be = 4'hf; end
            6'h28: begin
                e.dmwr = 1'b1;
                case (ao)
                    2'd0: e.be = 4'b0001;
                    2'd1: e.be = 4'b0010;
                    2'd2: e.be = 4'b0100;
                    default: e.be = 4'b1000;
                endcase
            end
            6'h29: if (ao == 2'd0) begin e.dmwr = 1'b1; e.be = 4'b0011; end
                   else if (ao == 2'd2) begin e.dmwr = 1'b1; e.be = 4'b1100; end
            6'h20, 6'h24, 6'h21, 6'h25: begin
                wr = 1'b1; e.a3 = w[20:16]; e.tnew = 2'd1;
            end
`else
            6'h2b: begin e.dmwr = 1'b1; e.be = 4'hf; end
`endif
            default: ;
        endcase
        e.regwr = wr && (e.a3 != 5'd0);
        if (!e.regwr) e.fwd = 2'b00;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic st, input logic fl,
                        input logic rn, input logic [1:0] ao);
        exp_t e;
        @(negedge clk);
        bus.instr_e = ins;
        bus.stall_m = st;
        bus.flush_m = fl;
        bus.ao_lo_m = ao;
        rst_n       = rn;
        if (!rn)       m_instr = '0;
        else if (fl)   m_instr = '0;
        else if (!st)  m_instr = ins;
        sb_q.push_back(model(m_instr, ao));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("op_m",     {26'd0, bus.op_m},     {26'd0, e.op});
            check("func_m",   {26'd0, bus.func_m},   {26'd0, e.fn});
            check("RegWr_M",  {31'd0, bus.RegWr_M},  {31'd0, e.regwr});
            check("A3_M",     {27'd0, bus.A3_M},     {27'd0, e.a3});
            check("DMWr_M",   {31'd0, bus.DMWr_M},   {31'd0, e.dmwr});
            check("BE_M",     {28'd0, bus.BE_M},     {28'd0, e.be});
            check("Tnew_M",   {30'd0, bus.Tnew_M},   {30'd0, e.tnew});
            check("FWDSEL_M", {30'd0, bus.FWDSEL_M}, {30'd0, e.fwd});
        end
    endtask

    logic [31:0] addu3, lw5, jal_i, ori0, sw4, subu7, lui9, beq_i, jr_i, j_i, bogus;
    logic [31:0] pool[12];

    initial begin
        total = 0;
        bad   = 0;
        m_instr = '0;
        rst_n = 1'b0;
        bus.instr_e = '0;
        bus.stall_m = 1'b0;
        bus.flush_m = 1'b0;
        bus.ao_lo_m = 2'b00;

        addu3 = rtype(5'd1, 5'd2, 5'd3, 6'h21);
        subu7 = rtype(5'd1, 5'd2, 5'd7, 6'h23);
        jr_i  = rtype(5'd31, 5'd0, 5'd0, 6'h08);
        lw5   = itype(6'h23, 5'd0, 5'd5, 16'd4);
        jal_i = {6'h03, 26'h0000100};
        j_i   = {6'h02, 26'h0000200};
        ori0  = itype(6'h0d, 5'd1, 5'd0, 16'd7);
        sw4   = itype(6'h2b, 5'd0, 5'd4, 16'd0);
        lui9  = itype(6'h0f, 5'd0, 5'd9, 16'h1234);
        beq_i = itype(6'h04, 5'd1, 5'd2, 16'd3);
        bogus = itype(6'h3f, 5'd3, 5'd8, 16'h5555);

        // Reset held with addu waiting, then released.
        step(addu3, 1'b0, 1'b0, 1'b0, 2'd0);
        check("rst_regwr", {31'd0, bus.RegWr_M}, 32'd0);
        step(addu3, 1'b0, 1'b0, 1'b0, 2'd0);
        step(addu3, 1'b0, 1'b0, 1'b1, 2'd0);
        check("plan_addu_a3", {27'd0, bus.A3_M}, 32'd3);
        check("plan_addu_fwd", {30'd0, bus.FWDSEL_M}, 32'd1);

        // lw then jal.
        step(lw5, 1'b0, 1'b0, 1'b1, 2'd0);
        check("plan_lw_tnew", {30'd0, bus.Tnew_M}, 32'd1);
        step(jal_i, 1'b0, 1'b0, 1'b1, 2'd0);
        check("plan_jal_fwd", {30'd0, bus.FWDSEL_M}, 32'd2);

        // Write to $0 suppressed; store word.
        step(ori0, 1'b0, 1'b0, 1'b1, 2'd0);
        step(sw4, 1'b0, 1'b0, 1'b1, 2'd0);
        check("plan_sw_be", {28'd0, bus.BE_M}, 32'hf);

        // Stall three cycles while instr_e changes, then advance.
        step(subu7, 1'b0, 1'b0, 1'b1, 2'd0);
        step(lui9,  1'b1, 1'b0, 1'b1, 2'd0);
        step(lw5,   1'b1, 1'b0, 1'b1, 2'd0);
        step(jal_i, 1'b1, 1'b0, 1'b1, 2'd0);
        check("plan_stall_a3", {27'd0, bus.A3_M}, 32'd7);
        step(lui9,  1'b0, 1'b0, 1'b1, 2'd0);
        // Flush beats stall.
        step(addu3, 1'b1, 1'b1, 1'b1, 2'd0);
        check("plan_flush_op", {26'd0, bus.op_m}, 32'd0);

        // Non-writing control flow and unknown opcode.
        step(beq_i, 1'b0, 1'b0, 1'b1, 2'd0);
        step(jr_i,  1'b0, 1'b0, 1'b1, 2'd0);
        step(j_i,   1'b0, 1'b0, 1'b1, 2'd0);
        step(bogus, 1'b0, 1'b0, 1'b1, 2'd0);
        // sw with nonzero low address bits.
        step(sw4, 1'b0, 1'b0, 1'b1, 2'd3);

`ifdef BYTE_MEM_EN
        step(itype(6'h28, 5'd0, 5'd4, 16'd2), 1'b0, 1'b0, 1'b1, 2'd2);
        check("plan_sb_be", {28'd0, bus.BE_M}, 32'h4);
        step(itype(6'h29, 5'd0, 5'd4, 16'd1), 1'b0, 1'b0, 1'b1, 2'd1);
        check("plan_sh_drop", {31'd0, bus.DMWr_M}, 32'd0);
        step(itype(6'h29, 5'd0, 5'd4, 16'd2), 1'b0, 1'b0, 1'b1, 2'd2);
        step(itype(6'h24, 5'd0, 5'd6, 16'd0), 1'b0, 1'b0, 1'b1, 2'd0);
        check("plan_lbu_a3", {27'd0, bus.A3_M}, 32'd6);
        step(itype(6'h20, 5'd0, 5'd0, 16'd0), 1'b0, 1'b0, 1'b1, 2'd0);
        step(itype(6'h21, 5'd0, 5'd8, 16'd0), 1'b0, 1'b0, 1'b1, 2'd0);
        step(itype(6'h25, 5'd0, 5'd9, 16'd0), 1'b0, 1'b0, 1'b1, 2'd0);
`endif

        // Reset in the middle of a lw sequence.
        step(lw5, 1'b0, 1'b0, 1'b1, 2'd0);
        step(lw5, 1'b0, 1'b0, 1'b0, 2'd0);
        check("plan_rst_op34", {26'd0, bus.op_m}, 32'd0);
        step(lw5, 1'b0, 1'b0, 1'b1, 2'd0);

        // Random mix.
        pool[0] = addu3; pool[1] = subu7; pool[2] = lw5; pool[3] = jal_i;
        pool[4] = ori0;  pool[5] = sw4;   pool[6] = lui9; pool[7] = beq_i;
        pool[8] = jr_i;  pool[9] = bogus;
        pool[10] = itype(6'h28, 5'd2, 5'd3, 16'd1);
        pool[11] = itype(6'h29, 5'd2, 5'd3, 16'd2);
        for (int i = 0; i < 80; i++) begin
            logic [31:0] ins;
            ins = pool[$urandom_range(0, 11)];
            if ($urandom_range(0, 3) == 0) ins[20:11] = 10'($urandom);
            step(ins, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)));
        end

        check("sb_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
